// File: rtl/r4booth_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
// Imported by the digit encoder and the top level.
package r4booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_e;

    // Number of Booth digits needed for a WIDTH+2 bit extended multiplier
    function automatic int calc_nd(input int width);
        return width / 2 + 1;
    endfunction

    // Busy cycles needed when retiring dpc digits per cycle
    function automatic int calc_nstep(input int width, input int dpc);
        return (calc_nd(width) + dpc - 1) / dpc;
    endfunction

endpackage

// File: rtl/r4booth_digit_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {one, two, neg}.
// Purely combinational; one copy per digit retired each cycle.
module r4booth_digit_enc
    import r4booth_pkg::*;
(
    input  logic [2:0] win,
    output logic       one,
    output logic       two,
    output logic       neg
);

    digit_e dig;

    // Map the window onto a signed digit in {-2..+2}
    always_comb begin
        dig = ZERO;
        case (win)
            3'b001, 3'b010: dig = POS1;
            3'b011:         dig = POS2;
            3'b100:         dig = NEG2;
            3'b101, 3'b110: dig = NEG1;
            default:        dig = ZERO;
        endcase
    end

    // Split the digit into magnitude selects and a negate flag
    always_comb begin
        one = 1'b0;
        two = 1'b0;
        neg = 1'b0;
        case (dig)
            POS1: one = 1'b1;
            POS2: two = 1'b1;
            NEG1: begin
                one = 1'b1;
                neg = 1'b1;
            end
            NEG2: begin
                two = 1'b1;
                neg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/r4booth_iter_mul.sv
// Iterative handshaked radix-4 Booth multiplier, DPC digits per cycle.
// Multiplicand shifts left and multiplier shifts right each step.
module r4booth_iter_mul
    import r4booth_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DPC   = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               busy_o
);

    localparam int NSTEP = calc_nstep(WIDTH, DPC);
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int XW    = WIDTH + 2;
    localparam int AW    = 2 * WIDTH + 2;
    // Padded so every window read over all steps stays inside the register
    localparam int MW    = 2 * DPC * NSTEP + 2;

    state_e          state;
    logic [SW-1:0]   step;
    logic [AW-1:0]   mcand;
    logic [MW-1:0]   mplier;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    logic [AW-1:0]   pp [DPC];
    logic [XW-1:0]   b_x;
    logic            a_sgn;
    logic            last;

    assign a_sgn      = signed_i & a_i[WIDTH-1];
    assign b_x        = {{2{signed_i & b_i[WIDTH-1]}}, b_i};
    assign last       = (step == SW'(NSTEP - 1));
    assign in_ready_o = (state == IDLE) & ~flush_i;
    assign busy_o     = (state != IDLE);

    // One partial product per digit retired this cycle
    for (genvar k = 0; k < DPC; k++) begin : g_dig
        logic [AW-1:0] sh;
        logic [AW-1:0] mag;
        logic          one;
        logic          two;
        logic          neg;

        r4booth_digit_enc u_enc (
            .win (mplier[2*k +: 3]),
            .one (one),
            .two (two),
            .neg (neg)
        );

        assign sh    = mcand << (2 * k);
        assign mag   = one ? sh : (two ? {sh[AW-2:0], 1'b0} : '0);
        assign pp[k] = neg ? -mag : mag;
    end

    // Accumulator plus DPC partial products
    always_comb begin
        acc_nxt = acc;
        for (int k = 0; k < DPC; k++) begin
            acc_nxt = acc_nxt + pp[k];
        end
    end

    // Control FSM with operand, accumulator and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            step        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            prod_o      <= '0;
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        mcand  <= {{(AW-WIDTH){a_sgn}}, a_i};
                        mplier <= {{(MW-XW-1){b_x[XW-1]}}, b_x, 1'b0};
                        acc    <= '0;
                        step   <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << (2 * DPC);
                    mplier <= {{(2*DPC){mplier[MW-1]}},
                               mplier[MW-1:2*DPC]};
                    step   <= step + SW'(1);
                    if (last) begin
                        prod_o      <= acc_nxt[2*WIDTH-1:0];
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/r4booth_iter_mul.md
# r4booth_iter_mul

Iterative, handshaked radix-4 Booth multiplier: accepts two WIDTH-bit operands, retires DPC Booth digits per clock into an internal accumulator, and presents the exact 2·WIDTH-bit product. Supports unsigned or two's-complement signed operands, selected per transaction. Sits in the MAC datapath as the area-optimised alternative to the fully parallel partial-product array, for lanes where multi-cycle latency is acceptable.

## Interface
- WIDTH, 24: operand width; even, ≥4 (24 = hidden bit + 23-bit mantissa).
- DPC, 1: Booth digits retired per cycle; 1 ≤ DPC ≤ ND.
- Derived ND = WIDTH/2 + 1 digits; NSTEP = ceil(ND/DPC) busy cycles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operands valid.
- in_ready_o  out  1  block can accept operands.
- a_i  in  WIDTH  multiplicand.
- b_i  in  WIDTH  multiplier (Booth-recoded).
- signed_i  in  1  1 = both operands two's-complement; 0 = unsigned.
- flush_i  in  1  synchronous abort of any transaction in flight.
- out_valid_o  out  1  product valid.
- out_ready_i  in  1  consumer takes product.
- prod_o  out  2·WIDTH  product.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready_o = ~flush_i. Accept on in_valid_i & in_ready_o. At accept, register a_i and b_i extended to WIDTH+2 bits (zero-extended if signed_i = 0, sign-extended if 1), clear accumulator and step counter, go to BUSY.
- Booth window for digit j: bits {2j+1, 2j, 2j−1} of the extended multiplier, with bit −1 = 0. Encoding: 000/111 → 0; 001/010 → +1; 011 → +2; 100 → −2; 101/110 → −1.
- BUSY: each cycle, add DPC partial products (digit × extended multiplicand, sign-extended, weighted 4^j) for digits j = step·DPC … step·DPC+DPC−1. Digits with j ≥ ND contribute 0. The accumulator is at least 2·WIDTH+2 bits. When step = NSTEP−1, go to DONE.
- DONE: out_valid_o = 1. prod_o = accumulator[2·WIDTH−1:0], which is exact for both modes. Hold until out_ready_i, then go to IDLE.
- flush_i = 1 in any state: next state IDLE and out_valid_o drops. flush_i beats a same-cycle accept or output handshake, so neither takes effect.
- No accept in BUSY or DONE; in_ready_o = 0 there.

## Timing
- Reset values: in_ready_o = 1 (subject to flush_i), out_valid_o = 0, prod_o = 0, busy_o = 0, state IDLE, all registers cleared. Reset acts immediately, including mid-transaction, and the transaction is lost.
- Latency: accept at edge T → out_valid_o high from edge T+NSTEP.
- Output handshake at edge U → IDLE from U+1, so the next accept is no earlier than edge U+1.
- Peak throughput: one product every NSTEP+2 cycles.
- prod_o and out_valid_o are registered and stable throughout DONE. prod_o is don't-care outside DONE.
- No combinational path from in_valid_i or a_i/b_i to any output. in_ready_o depends combinationally on flush_i only.

## Structure
- Package r4booth_pkg holds:
  - state enum (IDLE/BUSY/DONE);
  - Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2);
  - functions for ND and NSTEP from WIDTH/DPC.
- Sub-module r4booth_digit_enc: combinational 3-bit window → {one, two, neg}. Instantiate DPC copies.
- Top level holds the FSM, step counter (clog2(NSTEP) bits), operand registers, and accumulator adder tree of DPC+1 inputs.

## Test plan
- WIDTH=24, DPC=1, unsigned, 0xFFFFFF × 0xFFFFFF → prod_o = 0xFFFFFE000001; out_valid_o rises exactly 13 cycles after the accept edge.
- Signed: 0x800000 × 0x800000 → 0x400000000000. 0xFFFFFF × 0x000003 → 0xFFFFFFFFFFFD. The same operands unsigned give 0x2FFFFFD.
- Backpressure: hold out_ready_i = 0 for 5 cycles in DONE → prod_o and out_valid_o stable, in_ready_o = 0. Release → IDLE next cycle and a back-to-back accept succeeds.
- flush_i pulsed at BUSY step 6 → IDLE next cycle and out_valid_o never rises. Next transaction 0x000005 × 0x000007 → 0x23.
- rst_ni dropped mid-BUSY, between clock edges → all outputs at reset values before the next edge. After release, a fresh transaction is correct.
- DPC=4 (NSTEP=4), unsigned 0xC00000 × 0xC00000 → 0x900000000000 four cycles after accept. Also run a randomized signed/unsigned sweep against a reference product.
